// File: rtl/decode_stage_hz_if.sv
// ID/EX pipeline bus between the decode stage (master) and execute (slave).
interface decode_stage_hz_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_mem_read;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_jtarget;
    logic [REG_AW-1:0] ex_rs_addr;
    logic [REG_AW-1:0] ex_rt_addr;
    logic [REG_AW-1:0] ex_dest;
    logic [5:0]        ex_func;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_pc;

    modport master (
        output ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget,
               ex_rs_addr, ex_rt_addr, ex_dest, ex_func, ex_ctrl, ex_pc,
        input  ex_ready, ex_mem_read
    );

    modport slave (
        input  ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget,
               ex_rs_addr, ex_rt_addr, ex_dest, ex_func, ex_ctrl, ex_pc,
        output ex_ready, ex_mem_read
    );
endinterface

// File: rtl/decode_stage_hz.sv
// MUSA instruction-decode stage: register file with write-back bypass,
// immediate / jump-target generation, ID/EX register with valid/ready
// handshake, load-use bubble insertion, flush and a saturating stall counter.
module decode_stage_hz #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int CTRL_W     = 16,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              ctrl_reg_dst,
    output logic              id_ready,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    decode_stage_hz_if.master ex_bus,
    output logic [CNT_W-1:0]  stall_count
);
    localparam int unsigned NREG = 2 ** REG_AW;

    typedef enum logic {RUN, STALL} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] rf [NREG];

    logic [5:0]        opcode;
    logic [15:0]       imm16;
    logic [REG_AW-1:0] rs_a, rt_a, rd_a, dest_a;
    logic [DATA_W-1:0] rs_data, rt_data, imm_ext, jtarget;
    logic              adv, haz;
    logic [CNT_W-1:0]  stall_inc;

    // Field extraction, operand read with write-back bypass, immediate and jump target
    always_comb begin
        opcode = in_instr[31:26];
        imm16  = in_instr[15:0];
        rs_a   = REG_AW'(in_instr[25:21]);
        rt_a   = REG_AW'(in_instr[20:16]);
        rd_a   = REG_AW'(in_instr[15:11]);
        dest_a = ctrl_reg_dst ? rd_a : rt_a;

        if (rs_a == '0)
            rs_data = '0;
        else if (wb_we && (wb_addr == rs_a))
            rs_data = wb_data;
        else
            rs_data = rf[rs_a];

        if (rt_a == '0)
            rt_data = '0;
        else if (wb_we && (wb_addr == rt_a))
            rt_data = wb_data;
        else
            rt_data = rf[rt_a];

        case (opcode)
            6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_W'(imm16);
            6'h0F:               imm_ext = DATA_W'({imm16, 16'h0000});
            default:             imm_ext = DATA_W'(signed'(imm16));
        endcase

        jtarget = {in_pc[DATA_W-1:28], in_instr[25:0], 2'b00};
    end

    // Handshake, load-use hazard detection and saturating increment
    always_comb begin
        adv = ex_bus.ex_ready | ~ex_bus.ex_valid;
        haz = in_valid & ex_bus.ex_valid & ex_bus.ex_mem_read &
              (ex_bus.ex_dest != '0) &
              ((ex_bus.ex_dest == rs_a) | (ex_bus.ex_dest == rt_a));
        stall_inc = (stall_count == '1) ? stall_count : stall_count + CNT_W'(1);
        if (flush)
            id_ready = 1'b1;
        else if (state == RUN)
            id_ready = adv & ~haz;
        else
            id_ready = 1'b0;
    end

    // Architectural register file; register 0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rf <= '{default: '0};
        else if (wb_we && (wb_addr != '0))
            rf[wb_addr] <= wb_data;
    end

    // ID/EX register, bubble FSM and stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= RUN;
            cnt                <= '0;
            stall_count        <= '0;
            ex_bus.ex_valid    <= 1'b0;
            ex_bus.ex_rs_data  <= '0;
            ex_bus.ex_rt_data  <= '0;
            ex_bus.ex_imm      <= '0;
            ex_bus.ex_jtarget  <= '0;
            ex_bus.ex_rs_addr  <= '0;
            ex_bus.ex_rt_addr  <= '0;
            ex_bus.ex_dest     <= '0;
            ex_bus.ex_func     <= '0;
            ex_bus.ex_ctrl     <= '0;
            ex_bus.ex_pc       <= '0;
        end else if (flush) begin
            ex_bus.ex_valid <= 1'b0;
            state           <= RUN;
            cnt             <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (adv) begin
                        if (in_valid && id_ready) begin
                            ex_bus.ex_valid    <= 1'b1;
                            ex_bus.ex_rs_data  <= rs_data;
                            ex_bus.ex_rt_data  <= rt_data;
                            ex_bus.ex_imm      <= imm_ext;
                            ex_bus.ex_jtarget  <= jtarget;
                            ex_bus.ex_rs_addr  <= rs_a;
                            ex_bus.ex_rt_addr  <= rt_a;
                            ex_bus.ex_dest     <= dest_a;
                            ex_bus.ex_func     <= in_instr[5:0];
                            ex_bus.ex_ctrl     <= ctrl_in;
                            ex_bus.ex_pc       <= in_pc;
                        end else begin
                            ex_bus.ex_valid <= 1'b0;
                        end
                        if (haz) begin
                            stall_count <= stall_inc;
                            cnt         <= 3'(LU_BUBBLES - 1);
                            if (LU_BUBBLES > 1)
                                state <= STALL;
                        end
                    end
                end
                STALL: begin
                    // cnt holds the bubbles still owed; leave once the last one is issued
                    if (adv) begin
                        ex_bus.ex_valid <= 1'b0;
                        stall_count     <= stall_inc;
                        cnt             <= cnt - 3'd1;
                        if (cnt == 3'd1)
                            state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: two instances (1 and 3 load-use bubbles) share
// stimulus and are compared every cycle against a behavioural model.
module tb_decode_stage_hz;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [31:0]   in_instr;
    logic [DW-1:0] in_pc;
    logic [CW-1:0] ctrl_in;
    logic          ctrl_reg_dst;
    logic          flush;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          ex_ready;
    logic          id_ready1, id_ready3;
    logic [15:0]   sc1, sc3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_stage_hz_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) bus1 ();
    decode_stage_hz_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) bus3 ();

    // EX decodes "is a load" from bit 0 of the control word it holds
    assign bus1.ex_ready    = ex_ready;
    assign bus1.ex_mem_read = bus1.ex_ctrl[0];
    assign bus3.ex_ready    = ex_ready;
    assign bus3.ex_mem_read = bus3.ex_ctrl[0];

    decode_stage_hz #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .LU_BUBBLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .ctrl_in(ctrl_in), .ctrl_reg_dst(ctrl_reg_dst), .id_ready(id_ready1), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_bus(bus1.master),
        .stall_count(sc1)
    );

    decode_stage_hz #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .LU_BUBBLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .ctrl_in(ctrl_in), .ctrl_reg_dst(ctrl_reg_dst), .id_ready(id_ready3), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_bus(bus3.master),
        .stall_count(sc3)
    );

    // Reference model: what EX should see, plus number of bubbles still owed
    typedef struct {
        logic        v;
        logic [31:0] rs_d, rt_d, imm, jt, pc;
        logic [4:0]  rs, rt, dest;
        logic [5:0]  func;
        logic [15:0] ctrl;
        int          stall;
        int          owed;
    } mdl_t;

    mdl_t        m [2];
    int          lu [2] = '{1, 3};
    logic [31:0] regs [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int          op;
        logic [15:0] h;
        op = int'(ins[31:26]);
        h  = ins[15:0];
        if (op == 12 || op == 13 || op == 14) return {16'h0000, h};
        if (op == 15) return {h, 16'h0000};
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_we && wb_addr == a) return wb_data;
        return regs[a];
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i] = '{default: 0};
        end
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    endtask

    task automatic model_comb(input int i, output bit rdy, output bit hz, output bit adv);
        logic [4:0] rs, rt;
        rs  = in_instr[25:21];
        rt  = in_instr[20:16];
        hz  = in_valid && m[i].v && m[i].ctrl[0] && m[i].dest != 5'd0 &&
              (m[i].dest == rs || m[i].dest == rt);
        adv = ex_ready || !m[i].v;
        rdy = flush ? 1'b1 : (m[i].owed == 0 && adv && !hz);
    endtask

    task automatic model_next(input int i, input bit rdy, input bit hz, input bit adv, output mdl_t n);
        n = m[i];
        if (flush) begin
            n.v    = 1'b0;
            n.owed = 0;
        end else if (m[i].owed > 0) begin
            if (adv) begin
                n.v     = 1'b0;
                n.stall = sat_inc(m[i].stall);
                n.owed  = m[i].owed - 1;
            end
        end else if (adv) begin
            if (in_valid && rdy) begin
                n.v    = 1'b1;
                n.rs   = in_instr[25:21];
                n.rt   = in_instr[20:16];
                n.dest = ctrl_reg_dst ? in_instr[15:11] : in_instr[20:16];
                n.rs_d = ref_read(n.rs);
                n.rt_d = ref_read(n.rt);
                n.imm  = ref_imm(in_instr);
                n.jt   = {in_pc[31:28], in_instr[25:0], 2'b00};
                n.pc   = in_pc;
                n.func = in_instr[5:0];
                n.ctrl = ctrl_in;
            end else begin
                n.v = 1'b0;
            end
            if (hz) begin
                n.stall = sat_inc(m[i].stall);
                n.owed  = lu[i] - 1;
            end
        end
    endtask

    function automatic mdl_t grab(input int i);
        mdl_t o;
        o = '{default: 0};
        if (i == 0) begin
            o.v = bus1.ex_valid; o.rs_d = bus1.ex_rs_data; o.rt_d = bus1.ex_rt_data;
            o.imm = bus1.ex_imm; o.jt = bus1.ex_jtarget; o.pc = bus1.ex_pc;
            o.rs = bus1.ex_rs_addr; o.rt = bus1.ex_rt_addr; o.dest = bus1.ex_dest;
            o.func = bus1.ex_func; o.ctrl = bus1.ex_ctrl; o.stall = int'(sc1);
        end else begin
            o.v = bus3.ex_valid; o.rs_d = bus3.ex_rs_data; o.rt_d = bus3.ex_rt_data;
            o.imm = bus3.ex_imm; o.jt = bus3.ex_jtarget; o.pc = bus3.ex_pc;
            o.rs = bus3.ex_rs_addr; o.rt = bus3.ex_rt_addr; o.dest = bus3.ex_dest;
            o.func = bus3.ex_func; o.ctrl = bus3.ex_ctrl; o.stall = int'(sc3);
        end
        return o;
    endfunction

    task automatic check_outputs(input int i, input bit all_fields);
        mdl_t  o;
        string p;
        o = grab(i);
        p = $sformatf("lu%0d_", lu[i]);
        chk({p, "ex_valid"}, 64'(o.v), 64'(m[i].v));
        chk({p, "stall_count"}, 64'(o.stall), 64'(m[i].stall));
        if (m[i].v || all_fields) begin
            chk({p, "ex_rs_data"}, 64'(o.rs_d), 64'(m[i].rs_d));
            chk({p, "ex_rt_data"}, 64'(o.rt_d), 64'(m[i].rt_d));
            chk({p, "ex_imm"},     64'(o.imm),  64'(m[i].imm));
            chk({p, "ex_jtarget"}, 64'(o.jt),   64'(m[i].jt));
            chk({p, "ex_pc"},      64'(o.pc),   64'(m[i].pc));
            chk({p, "ex_rs_addr"}, 64'(o.rs),   64'(m[i].rs));
            chk({p, "ex_rt_addr"}, 64'(o.rt),   64'(m[i].rt));
            chk({p, "ex_dest"},    64'(o.dest), 64'(m[i].dest));
            chk({p, "ex_func"},    64'(o.func), 64'(m[i].func));
            chk({p, "ex_ctrl"},    64'(o.ctrl), 64'(m[i].ctrl));
        end
    endtask

    // One clock cycle: inputs already driven (called at a negedge)
    task automatic step();
        bit   rdy [2];
        bit   hz  [2];
        bit   adv [2];
        mdl_t nx  [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            model_comb(i, rdy[i], hz[i], adv[i]);
            chk($sformatf("lu%0d_id_ready", lu[i]), 64'(i == 0 ? id_ready1 : id_ready3), 64'(rdy[i]));
            model_next(i, rdy[i], hz[i], adv[i], nx[i]);
        end
        @(posedge clk);
        if (wb_we && wb_addr != 5'd0) regs[wb_addr] = wb_data;
        m = nx;
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i, 1'b0);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [15:0] ctl, input bit rdst);
        in_valid     = v;
        in_instr     = ins;
        in_pc        = pc;
        ctrl_in      = ctl;
        ctrl_reg_dst = rdst;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        wb_we    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        int    b1, b3;
        int    ops [8] = '{0, 'h23, 'h08, 'h0C, 'h0D, 'h0E, 'h0F, 'h02};
        int    op;

        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
        flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_outputs(i, 1'b1);
        rst = 1'b0;

        // Write-back bypass into the same-cycle read, and r0 stays zero
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        drive(1'b1, r_type(5, 5, 1, 'h20), 32'h100, 16'h0, 1'b1);
        step();
        chk("bypass_rs", 64'(bus1.ex_rs_data), 64'h0000_0000_DEAD_BEEF);
        chk("bypass_rt", 64'(bus1.ex_rt_data), 64'h0000_0000_DEAD_BEEF);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        drive(1'b1, r_type(0, 5, 2, 'h20), 32'h104, 16'h0, 1'b1);
        step();
        chk("r0_bypass_blocked", 64'(bus1.ex_rs_data), 64'h0);
        chk("r5_from_array", 64'(bus1.ex_rt_data), 64'h0000_0000_DEAD_BEEF);
        wb_we = 1'b0;
        drive(1'b1, r_type(0, 0, 3, 'h20), 32'h108, 16'h0, 1'b1);
        step();
        chk("r0_after_write", 64'(bus3.ex_rs_data), 64'h0);

        // Load-use: LW r4 then ADD r6,r4,r2; EX back-pressure first freezes the count
        idle(2);
        b1 = int'(sc1); b3 = int'(sc3);
        drive(1'b1, i_type('h23, 1, 4, 'h10), 32'h200, 16'h0001, 1'b0);
        step();
        drive(1'b1, r_type(4, 2, 6, 'h20), 32'h204, 16'h0000, 1'b1);
        ex_ready = 1'b0;
        step();
        step();
        chk("lu1_frozen", 64'(int'(sc1) - b1), 64'd0);
        chk("lu3_frozen", 64'(int'(sc3) - b3), 64'd0);
        chk("lu1_ready_blocked", 64'(id_ready1), 64'd0);
        ex_ready = 1'b1;
        repeat (4) step();
        chk("lu1_bubbles", 64'(int'(sc1) - b1), 64'd1);
        chk("lu3_bubbles", 64'(int'(sc3) - b3), 64'd3);
        chk("lu3_add_issued", 64'(bus3.ex_valid), 64'd1);
        chk("lu3_add_dest", 64'(bus3.ex_dest), 64'd6);

        // Immediate and jump-target forms
        idle(2);
        drive(1'b1, i_type('h0D, 0, 1, 'h8001), 32'h300, 16'h0, 1'b0);
        step();
        chk("ori_imm", 64'(bus1.ex_imm), 64'h0000_8001);
        drive(1'b1, i_type('h08, 0, 1, 'h8001), 32'h304, 16'h0, 1'b0);
        step();
        chk("addi_imm", 64'(bus1.ex_imm), 64'hFFFF_8001);
        drive(1'b1, i_type('h0F, 0, 1, 'h1234), 32'h308, 16'h0, 1'b0);
        step();
        chk("lui_imm", 64'(bus1.ex_imm), 64'h1234_0000);
        drive(1'b1, {6'h02, 26'h0000040}, 32'h4000_0004, 16'h0, 1'b0);
        step();
        chk("j_target", 64'(bus3.ex_jtarget), 64'h4000_0100);

        // Flush while the 3-bubble instance sits in its stall window
        idle(2);
        drive(1'b1, i_type('h23, 1, 4, 'h20), 32'h400, 16'h0001, 1'b0);
        step();
        drive(1'b1, r_type(4, 2, 6, 'h20), 32'h404, 16'h0000, 1'b1);
        step();
        b3 = int'(sc3);
        flush = 1'b1;
        drive(1'b1, r_type(3, 3, 9, 'h22), 32'h408, 16'h0000, 1'b1);
        step();
        chk("flush_lu3_valid", 64'(bus3.ex_valid), 64'd0);
        chk("flush_lu1_valid", 64'(bus1.ex_valid), 64'd0);
        chk("flush_count_kept", 64'(sc3), 64'(b3));
        flush = 1'b0;
        drive(1'b1, r_type(1, 2, 7, 'h21), 32'h40C, 16'h0000, 1'b1);
        step();
        chk("post_flush_accept", 64'(bus3.ex_valid), 64'd1);
        chk("post_flush_dest", 64'(bus3.ex_dest), 64'd7);

        // Randomised traffic on a small register window to provoke hazards
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ins;
            logic [15:0] ctl;
            op  = ops[$urandom_range(0, 7)];
            ins = $urandom;
            ins[31:26] = 6'(op);
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            ins[15:11] = 5'($urandom_range(0, 7));
            ctl    = 16'($urandom);
            ctl[0] = (op == 'h23);
            drive($urandom_range(0, 3) != 0, ins, $urandom, ctl, op == 0);
            wb_we    = $urandom_range(0, 1) != 0;
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            ex_ready = $urandom_range(0, 3) != 0;
            flush    = $urandom_range(0, 19) == 0;
            step();
        end

        // Asynchronous reset in the middle of a cycle with live ID/EX contents
        idle(3);
        drive(1'b1, r_type(1, 2, 3, 'h20), 32'h500, 16'h0, 1'b1);
        step();
        chk("pre_reset_valid", 64'(bus1.ex_valid), 64'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised instruction-decode stage for the MUSA pipeline; sits between the IF/ID register and the execute stage.
- Contains the architectural register file with write-back bypass, immediate/jump-target generation and a valid/ready-handshaked ID/EX pipeline register.
- Adds load-use hazard detection with a configurable bubble count, branch flush, and a saturating stall counter.
- Control decoding stays in the external control unit; its word enters on ctrl_in.

Parameters:
- DATA_W, 32: datapath width; must be >= 32.
- REG_AW, 5: register address width; register count is 2**REG_AW.
- CTRL_W, 16: width of the control word carried to EX.
- LU_BUBBLES, 1: bubbles inserted per load-use hazard, range 1..7.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  instruction valid from IF/ID
- in_instr  in  32  instruction word
- in_pc  in  DATA_W  PC+4 of the instruction
- ctrl_in  in  CTRL_W  control word for in_instr
- ctrl_reg_dst  in  1  1 = destination is rd [15:11], 0 = rt [20:16]
- id_ready  out  1  stage accepts in_instr this cycle
- flush  in  1  squash the ID instruction and the ID/EX contents
- wb_we  in  1  write-back enable
- wb_addr  in  REG_AW  write-back register
- wb_data  in  DATA_W  write-back data
- ex_ready  in  1  EX accepts the ID/EX contents
- ex_mem_read  in  1  ID/EX instruction is a load (decoded by EX from ex_ctrl)
- ex_valid  out  1  ID/EX contents valid
- ex_rs_data, ex_rt_data  out  DATA_W  operand values
- ex_imm  out  DATA_W  extended immediate
- ex_jtarget  out  DATA_W  jump target
- ex_rs_addr, ex_rt_addr, ex_dest  out  REG_AW  register addresses
- ex_func  out  6  in_instr[5:0]
- ex_ctrl  out  CTRL_W  registered ctrl_in
- ex_pc  out  DATA_W  registered in_pc
- stall_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, active-high): all registers cleared, ex_valid = 0, all ex_* = 0, stall_count = 0, FSM = RUN.
- Register file: register 0 reads 0, and writes to it are ignored.
  - The write occurs on the clk edge when wb_we = 1.
  - Same-cycle bypass: if wb_we = 1 and wb_addr == read address != 0, the read returns wb_data.
- Address fields: rs = in_instr[25:21], rt = in_instr[20:16], rd = in_instr[15:11], truncated or zero-extended to REG_AW.
- Immediate, selected by opcode in_instr[31:26]:
  - 0x0C/0x0D/0x0E: zero-extend.
  - 0x0F: imm << 16, zero-extended.
  - Otherwise: sign-extend.
- ex_jtarget = {in_pc[DATA_W-1:28], in_instr[25:0], 2'b00}.
- Advance condition: adv = ex_ready | ~ex_valid.
- Hazard: haz = in_valid & ex_valid & ex_mem_read & (ex_dest != 0) & (ex_dest == rs | ex_dest == rt).
- FSM:
  - RUN: id_ready = adv & ~haz.
    - In_valid & id_ready: ID/EX loads the instruction, ex_valid = 1.
    - Adv & ~(in_valid & id_ready): ex_valid <= 0.
    - Haz & adv: load bubble (ex_valid <= 0), stall_count += 1, cnt <= LU_BUBBLES-1, go to STALL if LU_BUBBLES > 1, else stay in RUN.
  - STALL: id_ready = 0.
    - Each adv cycle inserts a bubble, increments stall_count and decrements cnt.
    - cnt == 0 with adv: return to RUN.
    - ~adv: hold everything.
- When ex_ready = 0 and ex_valid = 1, all ex_* hold their values (no change while stalled by EX).
- Flush (priority over all but reset):
  - Next edge: ex_valid <= 0, FSM <= RUN.
  - id_ready = 1 during flush, so the ID instruction is consumed and discarded.
  - stall_count is unchanged.
- stall_count saturates at all-ones.
- Latency: one cycle from acceptance to ex_valid.

Test Plan:
- Reset mid-stream with ex_valid = 1 and stall_count = 3 -> outputs, ex_valid and stall_count read 0 immediately (asynchronous).
- Write r5 = 0xDEADBEEF via WB; same cycle present ADD r1,r5,r5 -> ex_rs_data = ex_rt_data = 0xDEADBEEF; a write to r0 leaves r0 reading 0.
- LW r4 in ID/EX (ex_mem_read = 1), present ADD r6,r4,r2 with LU_BUBBLES = 1 -> id_ready = 0 for one cycle, one bubble, ADD issues the next cycle, stall_count = 1.
- Same hazard with LU_BUBBLES = 3 -> three bubbles, stall_count = 3.
  - Hold ex_ready = 0 during the stall -> stall_count freezes.
- Immediates: ORI imm 0x8001 -> ex_imm = 0x00008001; ADDI imm 0x8001 -> 0xFFFF8001; LUI 0x1234 -> 0x12340000.
  - J 0x0000040 with in_pc = 0x40000004 -> ex_jtarget = 0x40000100.
- Flush asserted during STALL -> next cycle ex_valid = 0 and FSM = RUN; the ID instruction is discarded; the following instruction is accepted normally.
